// File: rtl/aes_key_sched_ctrl_if.sv
// Control and round-key stream bundle between key load logic, the AES-128
// key schedule controller and the round-key consumer.
interface aes_key_sched_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             abort;
  logic [127:0]     key;
  logic             busy;
  logic             done;
  logic             rk_valid;
  logic             rk_ready;
  logic [IDX_W-1:0] rk_index;
  logic [127:0]     rk_word;

  // master: key loader + consumer side; slave: the schedule controller
  modport master (
    output start, abort, key, rk_ready,
    input  busy, done, rk_valid, rk_index, rk_word
  );

  modport slave (
    input  start, abort, key, rk_ready,
    output busy, done, rk_valid, rk_index, rk_word
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: drives a shared combinational SubWord unit
// and streams round keys 0..NR over a valid/ready handshake.
module aes_key_sched_ctrl #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_sched_ctrl_if.slave  bus,
  output logic [31:0]          sub_in,
  input  logic [31:0]          sub_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [127:0]     cur_q;
  logic [127:0]     cur_d;
  logic [IDX_W-1:0] round_q;
  logic [7:0]       rcon_q;
  logic [7:0]       rcon_d;
  logic             done_q;

  logic [31:0]      t;
  logic [31:0]      n0;
  logic [31:0]      n1;
  logic [31:0]      n2;
  logic [31:0]      n3;
  logic             hs;
  logic             last;

  // Next round key is chained from w3 through the SubWord unit in one cycle
  always_comb begin
    sub_in = {cur_q[23:0], cur_q[31:24]};
    t      = sub_out ^ {rcon_q, 24'h0};
    n0     = cur_q[127:96] ^ t;
    n1     = cur_q[95:64]  ^ n0;
    n2     = cur_q[63:32]  ^ n1;
    n3     = cur_q[31:0]   ^ n2;
    cur_d  = {n0, n1, n2, n3};
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    hs     = (state_q == RUN) && bus.rk_ready;
    last   = (round_q == IDX_W'(NR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            cur_q   <= bus.key;
            round_q <= '0;
            rcon_q  <= 8'h01;
            state_q <= RUN;
          end
        end
        RUN: begin
          // abort outranks a same-cycle handshake and suppresses done
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (hs) begin
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cur_q   <= cur_d;
              round_q <= round_q + 1'b1;
              rcon_q  <= rcon_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.rk_valid = (state_q == RUN);
  assign bus.rk_word  = cur_q;
  assign bus.rk_index = round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: S-box built from GF(2^8)
// arithmetic, key schedule modelled with the word-recurrence form of AES-128.
module tb_aes_key_sched_ctrl;
  localparam int unsigned NR    = 10;
  localparam int unsigned IDX_W = 4;
  localparam logic [7:0] RCON [1:10] =
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sub_in;
  logic [31:0] sub_out;

  aes_key_sched_ctrl_if #(.IDX_W(IDX_W)) bus ();

  aes_key_sched_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sub_in (sub_in),
    .sub_out(sub_out)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox [0:255];
  assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]],
                    sbox[sub_in[15:8]],  sbox[sub_in[7:0]]};

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];
  int           xfers;
  logic [31:0]  first_sub;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic void build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
            ^ {RCON[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Streams one expansion; optional start poke, abort, or back-to-back restart.
  task automatic run_stream(input logic [127:0] k, input int ready_pct,
                            input int poke_idx, input int abort_idx,
                            input bit pre_started, input bit restart,
                            input logic [127:0] k_next);
    int           idx = 0;
    int           cyc = 0;
    bit           stalled = 1'b0;
    logic [127:0] pw = '0;
    logic [IDX_W-1:0] pi = '0;
    build_model(k);
    xfers = 0;
    if (!pre_started) begin
      @(negedge clk);
      bus.key = k; bus.start = 1'b1;
    end
    while (idx <= 10) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      if (cyc >= 400) begin
        n_checks++; n_fail++;
        $display("FAIL stream_timeout idx=%0d budget=%0d", idx, cyc);
        break;
      end
      if (cyc == 0) first_sub = sub_in;
      cyc++;
      n_checks++;
      if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_ctl valid/busy/done got=%b%b%b exp=110",
                 bus.rk_valid, bus.busy, bus.done);
      end
      n_checks++;
      if (bus.rk_index !== IDX_W'(idx)) begin
        n_fail++;
        $display("FAIL rk_index got=%0d exp=%0d", bus.rk_index, idx);
      end
      n_checks++;
      if (bus.rk_word !== exp_rk[idx]) begin
        n_fail++;
        $display("FAIL rk_word[%0d] got=%h exp=%h", idx, bus.rk_word, exp_rk[idx]);
      end
      if (stalled) begin
        n_checks++;
        if (bus.rk_word !== pw || bus.rk_index !== pi) begin
          n_fail++;
          $display("FAIL stall_hold got=%0d:%h exp=%0d:%h", bus.rk_index, bus.rk_word, pi, pw);
        end
      end
      pw = bus.rk_word; pi = bus.rk_index;
      if (poke_idx == idx) begin
        bus.start = 1'b1; bus.key = ~k;
      end
      if (abort_idx == idx) begin
        bus.abort = 1'b1; bus.rk_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.rk_ready = 1'b0;
        n_checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_ctl valid/busy/done got=%b%b%b exp=000",
                   bus.rk_valid, bus.busy, bus.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_no_done done/valid got=%b%b exp=00", bus.done, bus.rk_valid);
        end
        return;
      end
      bus.rk_ready = (int'($urandom_range(99)) < ready_pct);
      stalled = !bus.rk_ready;
      if (bus.rk_ready) begin
        got_rk[idx] = bus.rk_word;
        xfers++;
        idx++;
      end
    end
    @(negedge clk);
    bus.rk_ready = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse done/busy/valid got=%b%b%b exp=100",
               bus.done, bus.busy, bus.rk_valid);
    end
    if (restart) begin
      bus.key = k_next; bus.start = 1'b1;
      return;
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    n_checks++;
    if ({bus.busy, bus.done, bus.rk_valid} !== 3'b000 || bus.rk_word !== '0 ||
        bus.rk_index !== '0 || sub_in !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b%b%b %0d %h %h exp=zeros",
               bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.rk_word, sub_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.rk_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b%b%b exp=000", bus.busy, bus.done, bus.rk_valid);
    end
  endtask

  task automatic test_fips();
    run_stream(FIPS_KEY, 100, -1, -1, 1'b0, 1'b0, '0);
    n_checks++;
    if (first_sub !== 32'hcf4f3c09) begin
      n_fail++; $display("FAIL fips_sub_in got=%h exp=cf4f3c09", first_sub);
    end
    n_checks++;
    if (got_rk[0] !== FIPS_KEY) begin
      n_fail++; $display("FAIL fips_rk0 got=%h exp=%h", got_rk[0], FIPS_KEY);
    end
    n_checks++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++; $display("FAIL fips_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", got_rk[1]);
    end
    n_checks++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++; $display("FAIL fips_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
    end
  endtask

  task automatic test_zero_key();
    run_stream('0, 100, -1, -1, 1'b0, 1'b0, '0);
    n_checks++;
    if (got_rk[1] !== 128'h62636363626363636263636362636363) begin
      n_fail++; $display("FAIL zero_rk1 got=%h exp=62636363626363636263636362636363", got_rk[1]);
    end
    n_checks++;
    if (got_rk[2] !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa) begin
      n_fail++; $display("FAIL zero_rk2 got=%h exp=9b9898c9f9fbfbaa9b9898c9f9fbfbaa", got_rk[2]);
    end
    n_checks++;
    if (xfers !== 11) begin
      n_fail++; $display("FAIL zero_xfers got=%0d exp=11", xfers);
    end
  endtask

  task automatic test_backpressure();
    run_stream(FIPS_KEY, 50, -1, -1, 1'b0, 1'b0, '0);
    n_checks++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || xfers !== 11) begin
      n_fail++;
      $display("FAIL bp_fips got=%h/%0d exp=d014f9a8c9ee2589e13f0cc8b6630ca6/11", got_rk[10], xfers);
    end
    for (int i = 0; i < 3; i++)
      run_stream({$urandom, $urandom, $urandom, $urandom}, 30 + 20*i, -1, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_stream(FIPS_KEY, 100, 4, -1, 1'b0, 1'b1, k2);
    run_stream(k2, 70, -1, -1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_abort();
    run_stream({$urandom, $urandom, $urandom, $urandom}, 100, -1, 6, 1'b0, 1'b0, '0);
    run_stream({$urandom, $urandom, $urandom, $urandom}, 100, -1, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    @(negedge clk);
    bus.key = {$urandom, $urandom, $urandom, $urandom}; bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.rk_index !== 4'd3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.rk_index !== 4'd3) begin
      n_fail++; $display("FAIL areset_reach got=%0d exp=3", bus.rk_index);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.rk_valid} !== 3'b000 || bus.rk_word !== '0 ||
        bus.rk_index !== '0 || sub_in !== '0) begin
      n_fail++;
      $display("FAIL areset_zero got=%b%b%b %0d %h %h exp=zeros",
               bus.busy, bus.done, bus.rk_valid, bus.rk_index, bus.rk_word, sub_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rk_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.rk_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL areset_idle busy/done/valid got=%b%b%b exp=000",
                 bus.busy, bus.done, bus.rk_valid);
      end
    end
    run_stream({$urandom, $urandom, $urandom, $urandom}, 60, -1, -1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    bus.start = 1'b0; bus.abort = 1'b0; bus.key = '0; bus.rk_ready = 1'b0;
    test_reset();
    test_fips();
    test_zero_key();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
